// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: keeps one memory read in flight and buffers up
// to DEPTH fetched {instr, pc} entries ahead of decode, with branch redirect flush.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, REQ_STALE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;

  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];

  logic               ack, pop, push, room;
  logic [CNT_W-1:0]   count_after;
  logic [31:0]        redirect_pc;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^RedirectAddr[1:0];
  assign redirect_pc      = {RedirectAddr[31:2], 2'b00};

  assign ack         = req_q & imem_ack;
  assign pop         = (count_q != '0) & ~Stall & ~Redirect;
  assign push        = ack & (state_q == REQ) & ~Redirect;
  assign count_after = count_q - CNT_W'(pop) + CNT_W'(push);
  assign room        = count_after < CNT_W'(DEPTH);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_after;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    req_d      = req_q;
    addr_d     = addr_q;

    if (Redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      case (state_q)
        IDLE: begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end
        REQ, REQ_STALE: begin
          // An in-flight read can never be withdrawn; without its ack it is marked stale.
          if (ack) begin
            state_d = REQ;
            addr_d  = redirect_pc;
          end else begin
            state_d = REQ_STALE;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (room) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (room) begin
              addr_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        REQ_STALE: begin
          if (ack) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= addr_q;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign InstrValid = (count_q != '0);
  assign Instr      = InstrValid ? instr_mem[rd_ptr_q] : 32'h0;
  assign InstrPC    = InstrValid ? pc_mem[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a transaction-level model:
// a queue of fetched PCs plus one optional outstanding read.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Stall(Stall), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Model: fetched PCs in order, fetch PC, and the outstanding read (if any).
  logic [31:0] mq[$];
  logic [31:0] m_pc, m_addr;
  bit          m_out, m_stale;
  int          ack_mode, wait_cnt, stall_pct, redir_pct;

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC; m_addr = '0; m_out = 0; m_stale = 0; wait_cnt = 0;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] ra, input bit ack_in);
    bit ack;
    ack = ack_in && m_out;
    if (rd) begin
      mq.delete();
      m_pc = {ra[31:2], 2'b00};
      if (!m_out || ack) begin m_out = 1; m_addr = m_pc; m_stale = 0; end
      else m_stale = 1;
    end else begin
      if (mq.size() != 0 && !st) void'(mq.pop_front());
      if (ack) begin
        if (!m_stale) begin mq.push_back(m_addr); m_pc += 32'd4; end
        m_out = 0; m_stale = 0;
      end
      if (!m_out && mq.size() < DEPTH) begin m_out = 1; m_addr = m_pc; end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".req"}, {31'b0, imem_req}, {31'b0, m_out});
    if (m_out) check({tag, ".addr"}, imem_addr, m_addr);
    check({tag, ".valid"}, {31'b0, InstrValid}, {31'b0, mq.size() != 0});
    check({tag, ".instr"}, Instr, (mq.size() != 0) ? memf(mq[0]) : 32'h0);
    check({tag, ".pc"}, InstrPC, (mq.size() != 0) ? mq[0] : 32'h0);
  endtask

  task automatic step(input string tag, input bit st, input bit rd, input logic [31:0] ra, input bit ak);
    Stall = st; Redirect = rd; RedirectAddr = ra; imem_ack = ak;
    imem_rdata = ak ? memf(imem_addr) : 32'hDEAD_BEEF;
    @(posedge Clk);
    if (ak && m_out) wait_cnt = 0;
    model_edge(st, rd, ra, ak);
    @(negedge Clk);
    compare_all(tag);
  endtask

  task automatic auto_step(input string tag);
    bit st, rd, ak;
    logic [31:0] ra;
    st = $urandom_range(99) < stall_pct;
    rd = $urandom_range(99) < redir_pct;
    ra = $urandom & 32'h0000_FFFF;
    case (ack_mode)
      0: ak = 1'b1;
      1: ak = $urandom_range(1);
      default: begin
        if (m_out) wait_cnt++; else wait_cnt = 0;
        ak = wait_cnt >= 3;
      end
    endcase
    step(tag, st, rd, ra, ak);
  endtask

  initial begin
    bit found;
    Rst_n = 1'b0; Stall = 0; Redirect = 0; RedirectAddr = 0; imem_ack = 0; imem_rdata = 0;
    ack_mode = 0; stall_pct = 0; redir_pct = 0;
    model_reset();
    @(negedge Clk); @(negedge Clk);
    compare_all("reset");
    Rst_n = 1'b1;

    // Zero-wait memory, no stall: one instruction per cycle after the fill.
    for (int i = 0; i < 20; i++) begin
      auto_step("stream");
      if (i == 1) check("fill.pc0", InstrPC, 32'h0);
    end

    // Long stall fills the queue and stops requests; release resumes in order.
    stall_pct = 100;
    for (int i = 0; i < 10; i++) auto_step("stall");
    check("stall.req_drop", {31'b0, imem_req}, 32'h0);
    check("stall.full_valid", {31'b0, InstrValid}, 32'h1);
    stall_pct = 0;
    for (int i = 0; i < 10; i++) auto_step("resume");

    // Three-cycle memory; redirect to 0x103 while the read of 8 is in flight.
    ack_mode = 2;
    step("restart", 0, 1, 32'h0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_out && m_addr == 32'h8) found = 1;
      else auto_step("lat3");
    end
    check("lat3.found8", {31'b0, found}, 32'h1);
    step("lat3.redir", 0, 1, 32'h0000_0103, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      auto_step("lat3.after");
      if (InstrValid) found = 1;
    end
    check("lat3.got_valid", {31'b0, found}, 32'h1);
    check("lat3.first_pc", InstrPC, 32'h0000_0100);

    // Redirect coinciding with ack and pop on a nearly full queue.
    ack_mode = 0; stall_pct = 100;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && mq.size() == DEPTH - 1) found = 1;
      else auto_step("fill");
    end
    check("fill.reached", {31'b0, found}, 32'h1);
    step("redir_ack", 0, 1, 32'h0000_0200, 1);
    check("redir_ack.empty", {31'b0, InstrValid}, 32'h0);
    check("redir_ack.addr", imem_addr, 32'h0000_0200);
    stall_pct = 0;

    // Two redirects inside one stale window: only the latest target is fetched.
    step("stale.r1", 0, 1, 32'h0000_0040, 0);
    step("stale.hold", 0, 0, 32'h0, 0);
    step("stale.r2", 0, 1, 32'h0000_0080, 0);
    step("stale.ack", 0, 0, 32'h0, 1);
    check("stale.newaddr", imem_addr, 32'h0000_0080);
    step("stale.fetch", 0, 0, 32'h0, 1);
    check("stale.first_pc", InstrPC, 32'h0000_0080);

    // Random traffic with a mid-stream asynchronous reset.
    ack_mode = 1; stall_pct = 30; redir_pct = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 Rst_n = 1'b0;
        #1;
        check("arst.req", {31'b0, imem_req}, 32'h0);
        check("arst.addr", imem_addr, 32'h0);
        check("arst.valid", {31'b0, InstrValid}, 32'h0);
        check("arst.instr", Instr, 32'h0);
        check("arst.pc", InstrPC, 32'h0);
        model_reset();
        imem_ack = 1'b1;
        @(posedge Clk); @(negedge Clk);
        compare_all("in_reset");
        Rst_n = 1'b1;
        step("post_reset", 0, 0, 32'h0, 0);
        check("post_reset.addr", imem_addr, RESET_PC);
      end
      auto_step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
